// File: rtl/string_receiver.sv
// string_receiver: 8N1 UART receiver that assembles printable bytes into a
// line buffer up to LF, then holds the line (length, match flag, overflow)
// until the consumer acknowledges it. The buffer is read combinationally by address.
module string_receiver #(
  parameter  int CLK_FREQ = 100_000_000,
  parameter  int BAUD     = 115200,
  parameter  int MAX_LEN  = 16,
  localparam int AW       = $clog2(MAX_LEN),
  localparam int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    line_data,
  output logic [LW-1:0] line_len,
  output logic          line_valid,
  input  logic          line_ack,
  output logic          match,
  output logic          overflow,
  output logic          frame_err
);

  localparam int             CPB    = CLK_FREQ / BAUD;
  localparam int             CW     = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0]  HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0]  BIT_M1  = CW'(CPB - 1);
  localparam logic [95:0]    HELLO   = "Hello World!";

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          frame_err_q;

  logic [LW-1:0] wcnt_q;
  logic          line_valid_q, overflow_q, match_q, run_q;
  logic [7:0]    buf_q [MAX_LEN];

  // Bit-level FSM: synchronizer, start detection, mid-bit sampling, stop check
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q    <= '0;
            bitcnt_q <= '0;
            // A line that is high again at mid-start was only a glitch
            state_q  <= rx_s2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s2_q, shreg_q[7:1]};
            if (bitcnt_q == 3'd7) state_q <= STOP;
            else                  bitcnt_q <= bitcnt_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rx_s2_q) frame_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte classification at the stop-bit sample
  logic       byte_ok, ack_take, is_cr, is_lf, has_room;
  logic       store_en, lf_en, drop_en;
  logic [7:0] exp_byte;

  assign byte_ok  = (state_q == STOP) && (cnt_q == BIT_M1) && rx_s2_q;
  assign ack_take = line_valid_q && line_ack;
  assign is_cr    = (shreg_q == 8'h0D);
  assign is_lf    = (shreg_q == 8'h0A);
  assign has_room = (wcnt_q < LW'(MAX_LEN));
  assign store_en = byte_ok && !line_valid_q && !is_cr && !is_lf && has_room;
  assign lf_en    = byte_ok && !line_valid_q && is_lf && (wcnt_q != '0);
  assign drop_en  = byte_ok && !ack_take &&
                    (line_valid_q || (!is_cr && !is_lf && !has_room));

  // Reference character expected at the current write position
  always_comb begin
    exp_byte = 8'h00;
    for (int i = 0; i < 12; i++)
      if (int'(wcnt_q) == i) exp_byte = HELLO[8*(11-i) +: 8];
  end

  // Line state: write count, running compare, overflow, presentation/ack
  always_ff @(posedge clock) begin
    if (reset || ack_take) begin
      line_valid_q <= 1'b0;
      wcnt_q       <= '0;
      overflow_q   <= 1'b0;
      match_q      <= 1'b0;
      run_q        <= 1'b1;
    end else begin
      if (store_en) begin
        wcnt_q <= wcnt_q + 1'b1;
        run_q  <= run_q && (shreg_q == exp_byte);
      end
      if (lf_en) begin
        line_valid_q <= 1'b1;
        match_q      <= run_q && (int'(wcnt_q) == 12) && !overflow_q;
      end
      if (drop_en) overflow_q <= 1'b1;
    end
  end

  // Buffer storage; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (store_en) buf_q[wcnt_q[AW-1:0]] <= shreg_q;
  end

  assign line_data  = buf_q[rd_addr];
  assign line_len   = wcnt_q;
  assign line_valid = line_valid_q;
  assign match      = match_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_string_receiver.sv
// Scoreboard bench for string_receiver: the stimulus process queues the
// expected line for each message it sends; a monitor process pops and checks
// whenever line_valid rises, reads the buffer, then acknowledges the line.
module tb_string_receiver;

  localparam int MAX_LEN = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] rd_addr;
  logic [7:0] line_data;
  logic [4:0] line_len;
  logic       line_valid, line_ack, match, overflow, frame_err;

  string_receiver #(.CLK_FREQ(1_000_000), .BAUD(100_000), .MAX_LEN(MAX_LEN)) dut (
    .clock(clock), .reset(reset), .rx(rx), .rd_addr(rd_addr),
    .line_data(line_data), .line_len(line_len), .line_valid(line_valid),
    .line_ack(line_ack), .match(match), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           len;
    bit           m;
    bit           ovf;
    bit           ovf_after;
    int           hold;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, fe_cnt = 0;
  bit   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0; tick(10);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(10); end
    rx = stop; tick(10);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic push_line(input string s, input bit m, input bit ovf,
                           input int hold, input bit ovf_after);
    exp_t e;
    e.len = s.len(); e.m = m; e.ovf = ovf; e.hold = hold; e.ovf_after = ovf_after;
    e.data = '0;
    for (int i = 0; i < s.len(); i++) e.data[i*8 +: 8] = s[i];
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((q.size() != 0 || mon_busy || line_valid) && t < 3000) begin
      tick(1); t++;
    end
    check(name, (t < 3000), 1);
  endtask

  // frame_err pulse counter
  always @(negedge clock) if (!reset && frame_err) fe_cnt++;

  // Monitor: on each new line, compare against the scoreboard head and release it
  initial begin
    bit seen = 1'b0;
    exp_t e;
    line_ack = 1'b0;
    rd_addr  = '0;
    forever begin
      @(negedge clock);
      if (!line_valid) seen = 1'b0;
      else if (!seen && !reset) begin
        seen = 1'b1;
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          check("unexpected_line", 1, 0);
        end else begin
          e = q.pop_front();
          check("line_len", line_len, e.len);
          check("match", match, e.m);
          check("overflow", overflow, e.ovf);
          for (int i = 0; i < e.len; i++) begin
            rd_addr = 4'(i);
            #1;
            check("line_data", line_data, e.data[i*8 +: 8]);
          end
          tick(e.hold);
          check("overflow_before_ack", overflow, e.ovf_after);
          check("valid_held", line_valid, 1);
          line_ack = 1'b1;
          tick(1);
          line_ack = 1'b0;
          check("valid_after_ack", line_valid, 0);
          check("ovf_after_ack", overflow, 0);
          check("len_after_ack", line_len, 0);
        end
        seen = 1'b0;
        mon_busy = 1'b0;
      end
    end
  end

  // Hard stop if something hangs beyond any waited bound
  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int t;
    rx = 1'b1;
    reset = 1'b1;
    tick(5);
    check("rst_valid", line_valid, 0);
    check("rst_len", line_len, 0);
    check("rst_match", match, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b0;
    tick(5);

    // Reference line with CR, back-to-back frames
    push_line("Hello World!", 1, 0, 5, 0);
    send_str("Hello World!\r\n");
    wait_idle("hello_release");

    // Short line, non-matching
    push_line("Hi", 0, 0, 5, 0);
    send_str("Hi\n");
    wait_idle("hi_release");

    // Overflow: 20 bytes into a 16-byte buffer
    push_line("AAAAAAAAAAAAAAAA", 0, 1, 5, 1);
    for (int i = 0; i < 20; i++) send_byte(8'h41, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_idle("ovf_release");

    // Bad stop bit, then a short glitch
    send_byte(8'h55, 1'b0);
    tick(20);
    rx = 1'b0; tick(3); rx = 1'b1;
    tick(30);
    check("frame_err_count", fe_cnt, 1);
    check("ferr_no_line", line_valid, 0);
    check("ferr_no_store", line_len, 0);
    push_line("OK", 0, 0, 5, 0);
    send_str("OK\n");
    wait_idle("ok_release");

    // Byte arriving while a line is held
    push_line("AB", 0, 0, 300, 1);
    send_str("AB\n");
    t = 0;
    while (!line_valid && t < 500) begin tick(1); t++; end
    check("held_wait", (t < 500), 1);
    send_str("X");
    wait_idle("held_release");
    push_line("Hello World!", 1, 0, 5, 0);
    send_str("Hello World!\n");
    wait_idle("hello2_release");

    // Reset in the middle of a data bit of 'Q' (0x51)
    rx = 1'b0; tick(10);
    rx = 1'b1; tick(10);
    rx = 1'b0; tick(10);
    rx = 1'b0; tick(5);
    reset = 1'b1;
    tick(1);
    check("midrst_valid", line_valid, 0);
    check("midrst_len", line_len, 0);
    check("midrst_match", match, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_ferr", frame_err, 0);
    rx = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(20);
    push_line("Hello World!", 1, 0, 5, 0);
    send_str("Hello World!\r\n");
    wait_idle("hello3_release");

    check("scoreboard_empty", q.size(), 0);
    check("frame_err_total", fe_cnt, 1);
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/string_receiver.md
# string_receiver

UART receive-side line assembler, the receive counterpart of the team's string transmitter. Deserialises 8N1 frames from `rx` and collects printable bytes into a line buffer until LF. It then presents the completed line, its length and a fixed-string match flag to the consumer. The consumer reads the line by address and releases it with `line_ack`. Typical use is a loopback check against the transmitter's "Hello World!\r\n" output.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz.
- `BAUD`, 115200, bit rate. `CPB = CLK_FREQ/BAUD` (integer division), cycles per bit.
- `MAX_LEN`, 16, line buffer depth in bytes (2..255).
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial input, idle high.
- `rd_addr`  in  $clog2(MAX_LEN)  line buffer read address.
- `line_data`  out  8  buffer byte at `rd_addr`, combinational read.
- `line_len`  out  $clog2(MAX_LEN+1)  number of stored bytes in the presented line.
- `line_valid`  out  1  completed line held; level signal.
- `line_ack`  in  1  consumer releases the line; honoured only while `line_valid`=1.
- `match`  out  1  line equals "Hello World!" (12 bytes). Qualified by `line_valid`.
- `overflow`  out  1  bytes were lost for the current line. Sticky until ack.
- `frame_err`  out  1  one-cycle pulse per frame with bad stop bit.

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1) before all further use.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge (previous synced sample 1, current 0) enters START and clears the bit counter.
  - START: at count `CPB/2-1`, sample the line.
    - 0: enter DATA, counter restarts.
    - 1: false start, return to IDLE.
  - DATA: sample every `CPB` cycles, LSB first. After 8 bits, enter STOP.
  - STOP: sample after `CPB` cycles, then return to IDLE.
    - 1: byte accepted.
    - 0: pulse `frame_err`, discard the byte.
- Accepted byte handling:
  - 0x0D (CR): ignored.
  - 0x0A (LF) with write count > 0: assert `line_valid`, freeze `line_len`/`match`/`overflow`.
  - LF with count 0: ignored; no empty lines are presented.
  - Any other byte: stored at the write pointer if count < `MAX_LEN`. Otherwise dropped and `overflow` set.
  - Any byte while `line_valid`=1 is dropped and `overflow` set.
- `match` is computed incrementally: a per-position running compare against the constant string.
  - Final value = running compare AND count==12 AND no overflow.
- On `line_ack` with `line_valid`=1, the next edge clears `line_valid`, `overflow`, `match` and the write count.
- Ack and byte acceptance in the same cycle: ack wins, the byte is dropped, and `overflow` stays 0.
- `line_data` for `rd_addr >= line_len` is don't-care.

## Timing
- Reset values:
  - Outputs: `line_valid`=0, `line_len`=0, `match`=0, `overflow`=0, `frame_err`=0.
  - Internal: FSM=IDLE, synchronizer=1, write count 0. Buffer contents are not reset.
- Reset mid-frame aborts the frame; no partial byte is stored.
- Synchronizer latency is 2 cycles from the `rx` pin.
- The middle of each data bit is sampled `CPB/2 + k*CPB` cycles after the synced falling edge (k = 1..8). The stop bit is sampled at `CPB/2 + 9*CPB`.
- `line_valid` rises on the edge following the LF stop-bit sample cycle. `frame_err` pulses in that same position for a bad frame.
- `line_valid` falls one edge after the `line_ack` cycle. The receiver keeps deserialising throughout; no back-pressure on `rx`.
- A new falling edge is accepted in the first IDLE cycle after STOP, so back-to-back frames are supported.

## Test plan
Run with `CLK_FREQ`=1_000_000, `BAUD`=100_000 (`CPB`=10), `MAX_LEN`=16.
- Send "Hello World!\r\n" -> `line_valid`=1, `line_len`=12, `match`=1, `overflow`=0. `rd_addr`=0 gives 0x48; `rd_addr`=11 gives 0x21.
- Send "Hi\n", hold 5 cycles, pulse `line_ack` -> `line_len`=2, `match`=0. `line_valid` is 0 on the next edge.
- Send 20×0x41 then LF -> `line_len`=16, `overflow`=1, `match`=0. Every address reads 0x41.
- Send a frame with stop bit 0, then a 3-cycle low glitch -> one `frame_err` pulse, nothing stored. Following "OK\n" gives `line_len`=2.
- While a line is held, send "X" -> `overflow`=1. After ack, "Hello World!\n" gives `match`=1, `overflow`=0.
- Assert `reset` mid-data-bit of "Q" -> all outputs 0 the next cycle. A subsequent "Hello World!\r\n" is received correctly.
